// File: rtl/hex_scan_mux.sv
// hex_scan_mux: scans a multi-digit hex value onto one nibble bus,
// with active-low digit enables and frame-aligned value updates.
// Optional: HEX_SCAN_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module hex_scan_mux #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic                    load,
   output logic                    pending,
   output logic                    ack,
   output logic [3:0]              hex,
   output logic [NUM_DIGITS-1:0]   digit_en
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]           presc;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] shadow;
   logic [4*NUM_DIGITS-1:0] disp;
   logic                    tick;
   logic                    frame;
   logic [3:0]              cur_nib;
   logic                    blank;

   // tick ends a digit slot; a tick on the last digit ends the frame
   always_comb begin
      tick    = (presc == PRESC_MAX);
      frame   = tick && (idx == IDX_MAX);
      cur_nib = disp[4*idx +: 4];
   end

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] zero_above;
   logic                  run;

   // zero_above[i]: nibbles i..top of disp are all zero
   always_comb begin
      zero_above = '0;
      run        = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         run           = run && (disp[4*i +: 4] == 4'h0);
         zero_above[i] = run;
      end
      blank = (idx != '0) && zero_above[idx];
   end
`else
   // every digit is lit in its slot
   always_comb begin
      blank = 1'b0;
   end
`endif

   // prescaler and digit index
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc <= '0;
         idx   <= '0;
      end else if (tick) begin
         presc <= '0;
         idx   <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // capture into shadow; hand over to disp only at a frame boundary
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow  <= '0;
         disp    <= '0;
         pending <= 1'b0;
         ack     <= 1'b0;
      end else if (load) begin
         shadow  <= data_in;
         pending <= 1'b1;
         ack     <= 1'b0;
      end else if (frame && pending) begin
         disp    <= shadow;
         pending <= 1'b0;
         ack     <= 1'b1;
      end else begin
         ack     <= 1'b0;
      end
   end

   // registered nibble and one-cold digit enable for the current slot
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hex      <= 4'h0;
         digit_en <= '1;
      end else begin
         hex      <= cur_nib;
         digit_en <= blank ? '1 : ~(NUM_DIGITS'(1) << idx);
      end
   end

endmodule

// File: tb/tb_hex_scan_mux.sv
// tb_hex_scan_mux: randomized and directed stimulus, with a frame-level
// reference model feeding a scoreboard queue checked every cycle.
module tb_hex_scan_mux;

   localparam int N = 4;
   localparam int R = 4;
   localparam int F = N * R;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [15:0] data_in = 16'h0;
   logic        pending;
   logic        ack;
   logic [3:0]  hex;
   logic [3:0]  digit_en;

   always #5 clk = ~clk;

   hex_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .data_in(data_in),
      .load(load),
      .pending(pending),
      .ack(ack),
      .hex(hex),
      .digit_en(digit_en)
   );

   typedef struct {
      logic [3:0] hex;
      logic [3:0] en;
      logic       ack;
      logic       pend;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          failures = 0;
   int          k = 0;
   logic [15:0] disp_m = 16'h0;
   logic [15:0] shadow_m = 16'h0;
   logic        pend_m = 1'b0;
   int          ack_seen = 0;
   int          off_cnt = 0;
   bit          shown1 = 1'b0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  name, act, exp, $time);
      end
   endtask

   // reference: k counts edges since reset release; slot and frame
   // boundaries follow from k by division
   always @(posedge clk) begin : model
      exp_t e;
      int   s;
      bit   bnd;
      if (!rst_n) begin
         k        = 0;
         disp_m   = 16'h0;
         shadow_m = 16'h0;
         pend_m   = 1'b0;
         e.hex    = 4'h0;
         e.en     = 4'hF;
         e.ack    = 1'b0;
         e.pend   = 1'b0;
      end else begin
         k++;
         s     = ((k - 1) / R) % N;
         e.hex = disp_m[4*s +: 4];
         e.en  = ~(4'b0001 << s);
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
         if (s > 0 && (disp_m >> (4 * s)) == 16'h0)
            e.en = 4'hF;
`endif
         bnd = (k % F) == 0;
         if (load) begin
            shadow_m = data_in;
            pend_m   = 1'b1;
            e.ack    = 1'b0;
         end else if (bnd && pend_m) begin
            disp_m = shadow_m;
            pend_m = 1'b0;
            e.ack  = 1'b1;
         end else begin
            e.ack = 1'b0;
         end
         e.pend = pend_m;
      end
      q.push_back(e);
   end

   // monitor: pop one expectation per cycle and compare
   always @(negedge clk) begin : monitor
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("hex", {28'h0, hex}, {28'h0, e.hex});
         check("digit_en", {28'h0, digit_en}, {28'h0, e.en});
         check("ack", {31'h0, ack}, {31'h0, e.ack});
         check("pending", {31'h0, pending}, {31'h0, e.pend});
      end
      if (ack === 1'b1) ack_seen++;
      if (digit_en === 4'hF) off_cnt++;
      if (digit_en !== 4'hF && hex === 4'h1) shown1 = 1'b1;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_load(input logic [15:0] v);
      load    = 1'b1;
      data_in = v;
      step(1);
      load    = 1'b0;
   endtask

   task automatic wait_mod(input int m);
      int b;
      b = 0;
      step(1);
      while ((k % F) != m && b < 64) begin
         step(1);
         b++;
      end
      check("wait_mod", k % F, m);
   endtask

   int a0;

   initial begin
      rst_n = 1'b0;
      step(3);
      rst_n = 1'b1;
      step(2);

      a0 = ack_seen;
      wait_mod(5);
      do_load(16'h3B1F);
      step(2 * F);
      check("scan_ack_count", ack_seen - a0, 1);

      a0 = ack_seen;
      wait_mod(2);
      do_load(16'h1111);
      step(1);
      do_load(16'h2222);
      wait_mod(2);
      shown1 = 1'b0;
      step(F);
      check("lvw_ack_count", ack_seen - a0, 1);
      check("lvw_one_shown", {31'h0, shown1}, 0);

      wait_mod(15);
      a0 = ack_seen;
      do_load(16'h4444);
      step(4);
      check("bnd_no_ack", ack_seen - a0, 0);
      check("bnd_pending", {31'h0, pending}, 1);
      step(F - 4);
      step(2);
      check("bnd_ack_next", ack_seen - a0, 1);

      wait_mod(3);
      do_load(16'h5A5A);
      step(1);
      check("rst_pending_pre", {31'h0, pending}, 1);
      rst_n = 1'b0;
      step(2);
      check("rst_pending", {31'h0, pending}, 0);
      rst_n = 1'b1;
      a0 = ack_seen;
      step(2 * F);
      check("rst_no_ack", ack_seen - a0, 0);

      wait_mod(3);
      do_load(16'h0050);
      wait_mod(1);
      off_cnt = 0;
      step(F);
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
      check("blank_0050", off_cnt, 8);
`else
      check("blank_0050", off_cnt, 0);
`endif
      wait_mod(3);
      do_load(16'h0000);
      wait_mod(1);
      off_cnt = 0;
      step(F);
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
      check("blank_0000", off_cnt, 12);
`else
      check("blank_0000", off_cnt, 0);
`endif

      repeat (400) begin
         load    = ($urandom_range(0, 7) == 0);
         data_in = 16'($urandom);
         step(1);
      end
      load = 1'b0;
      step(2 * F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
